// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter slice:
//   - UART_DATA_W      : payload width of one character (8)
//   - uart_tx_state_t  : transmitter FSM state encoding
//   - calc_div()       : rounded clocks-per-bit from clock and baud rate
//   - even_parity()    : parity bit helper (only with UART_TX_PARITY_EN)
// Configuration macro: UART_TX_PARITY_EN adds the PARITY state (8E1/8E2).
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_DATA_W = 8;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_tx_state_t;

  // Even parity: the extra bit makes the total count of ones even.
  function automatic logic even_parity(input logic [UART_DATA_W-1:0] data);
    return ^data;
  endfunction
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd4
  } uart_tx_state_t;
`endif

  // Clocks per bit, rounded to nearest.
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Small synchronous FIFO buffering bytes ahead of the UART shifter.
// Flags and level are registered so that the ready signal seen upstream
// never depends combinationally on the push request.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push, push_data write request / data (ignored while full)
//   pop             read request (ignored while empty)
//   head            data at the read pointer (valid when !empty)
//   full, empty     registered status flags
//   level           registered occupancy
//   level_next      occupancy after the current edge (for registered status
//                   outputs elsewhere)
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
// Configuration macro UART_TX_PARITY_EN: not used in this file.
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int  DEPTH = 4,
  parameter int  WIDTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level,
  output logic [LVL_W-1:0] level_next
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [LVL_W-1:0] level_r;
  logic [LVL_W-1:0] level_next_s;
  logic             full_r;
  logic             empty_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign push_ok_s  = push && !full_r;
  assign pop_ok_s   = pop && !empty_r;
  assign head       = mem_r[rd_ptr_r];
  assign full       = full_r;
  assign empty      = empty_r;
  assign level      = level_r;
  assign level_next = level_next_s;

  // Occupancy after this edge; simultaneous push and pop leave it unchanged.
  always_comb begin
    level_next_s = level_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   level_next_s = level_r + LVL_W'(1);
      2'b01:   level_next_s = level_r - LVL_W'(1);
      default: level_next_s = level_r;
    endcase
  end

  // Pointers, level and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      level_r  <= {LVL_W{1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      level_r <= level_next_s;
      full_r  <= (level_next_s == LVL_W'(DEPTH));
      empty_r <= (level_next_s == {LVL_W{1'b0}});
    end
  end

  // Storage array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
// UART transmitter: bytes arrive on a valid/ready handshake, are queued in
// uart_tx_fifo and sent LSB-first as 8N1 / 8N2 frames (8E1 / 8E2 when the
// parity option is built in). Back-to-back frames have no idle gap.
// Ports:
//   aclk          system clock
//   aresetn       asynchronous reset, active-low
//   i_data        byte to send
//   i_valid       i_data valid; transfer on a rising edge with o_ready
//   o_ready       FIFO can accept (registered, independent of i_valid)
//   O_UART_TX     serial line, idle high (registered)
//   o_busy        frame in progress or bytes still queued (registered)
//   o_fifo_level  bytes queued, excluding the byte in the shifter
// Parameters: CLK_HZ, BAUD (DIV = rounded CLK_HZ/BAUD, must be >= 2),
//   FIFO_DEPTH (power of two >= 2), STOP_BITS (1 or 2).
// Configuration macro: UART_TX_PARITY_EN inserts an even-parity bit.
// -----------------------------------------------------------------------------
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS  = 1
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [7:0]                   i_data,
  input  logic                         i_valid,
  output logic                         o_ready,
  output logic                         O_UART_TX,
  output logic                         o_busy,
  output logic [$clog2(FIFO_DEPTH):0]  o_fifo_level
);

  localparam int DIV   = calc_div(CLK_HZ, BAUD);
  localparam int CNT_W = $clog2(DIV);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [2:0] LAST_DATA = 3'd7;
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  uart_tx_state_t         state_r;
  uart_tx_state_t         state_next_s;
  logic [CNT_W-1:0]       cnt_r;
  logic [2:0]             bit_idx_r;
  logic [UART_DATA_W-1:0] shift_r;
  logic                   tx_r;
  logic                   busy_r;
  logic                   line_s;
  logic                   pop_s;
  logic                   bit_end_s;
  logic                   stop_done_s;
  logic [UART_DATA_W-1:0] fifo_head_s;
  logic                   fifo_full_s;
  logic                   fifo_empty_s;
  logic [LVL_W-1:0]       fifo_level_s;
  logic [LVL_W-1:0]       fifo_level_next_s;
`ifdef UART_TX_PARITY_EN
  logic                   parity_r;
`endif

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_W)
  ) u_fifo (
    .clk        (aclk),
    .rst_n      (aresetn),
    .push       (i_valid),
    .push_data  (i_data),
    .pop        (pop_s),
    .head       (fifo_head_s),
    .full       (fifo_full_s),
    .empty      (fifo_empty_s),
    .level      (fifo_level_s),
    .level_next (fifo_level_next_s)
  );

  assign bit_end_s   = (cnt_r == CNT_W'(DIV - 1));
  assign stop_done_s = bit_end_s && (bit_idx_r == LAST_STOP);

  assign o_ready      = !fifo_full_s;
  assign o_fifo_level = fifo_level_s;
  assign O_UART_TX    = tx_r;
  assign o_busy       = busy_r;

  // FSM state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          state_next_s = ST_START;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          state_next_s = ST_DATA;
        end else begin
          state_next_s = ST_START;
        end
      end
      ST_DATA: begin
        if (bit_end_s && (bit_idx_r == LAST_DATA)) begin
`ifdef UART_TX_PARITY_EN
          state_next_s = ST_PARITY;
`else
          state_next_s = ST_STOP;
`endif
        end else begin
          state_next_s = ST_DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end_s) begin
          state_next_s = ST_STOP;
        end else begin
          state_next_s = ST_PARITY;
        end
      end
`endif
      ST_STOP: begin
        // Chain straight into the next start bit when more data is queued.
        if (stop_done_s) begin
          state_next_s = fifo_empty_s ? ST_IDLE : ST_START;
        end else begin
          state_next_s = ST_STOP;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // FSM outputs: line level for this cycle and FIFO pop request.
  always_comb begin
    line_s = 1'b1;
    pop_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        line_s = 1'b1;
        pop_s  = !fifo_empty_s;
      end
      ST_START: line_s = 1'b0;
      ST_DATA:  line_s = shift_r[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: line_s = parity_r;
`endif
      ST_STOP: begin
        line_s = 1'b1;
        pop_s  = stop_done_s && !fifo_empty_s;
      end
      default: begin
        line_s = 1'b1;
        pop_s  = 1'b0;
      end
    endcase
  end

  // Baud counter and bit index; both restart on every state change.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_r     <= {CNT_W{1'b0}};
      bit_idx_r <= 3'd0;
    end else if ((state_next_s != state_r) || (state_r == ST_IDLE)) begin
      cnt_r     <= {CNT_W{1'b0}};
      bit_idx_r <= 3'd0;
    end else if (bit_end_s) begin
      cnt_r     <= {CNT_W{1'b0}};
      bit_idx_r <= bit_idx_r + 3'd1;
    end else begin
      cnt_r     <= cnt_r + CNT_W'(1);
    end
  end

  // Shift register: loaded on pop, shifted right at each data bit boundary.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      shift_r <= {UART_DATA_W{1'b0}};
    end else if (pop_s) begin
      shift_r <= fifo_head_s;
    end else if ((state_r == ST_DATA) && bit_end_s) begin
      shift_r <= {1'b0, shift_r[UART_DATA_W-1:1]};
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity of the byte in flight, captured when it leaves the FIFO.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      parity_r <= 1'b0;
    end else if (pop_s) begin
      parity_r <= even_parity(fifo_head_s);
    end
  end
`endif

  // Registered outputs; busy uses next-cycle values so it lines up with state.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tx_r   <= 1'b1;
      busy_r <= 1'b0;
    end else begin
      tx_r   <= line_s;
      busy_r <= (state_next_s != ST_IDLE) || (fifo_level_next_s != {LVL_W{1'b0}});
    end
  end

endmodule
